// File: rtl/exec_flag_reg.sv
// exec_flag_reg: execute-stage output register with Z/V/N condition flags and branch evaluation.
// Define FLAG_BYPASS_EN to let br_taken see flag values being written in the same cycle.
module exec_flag_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  op_class,
    input  logic [15:0] result,
    input  logic        zr_in,
    input  logic        ov_in,
    input  logic [3:0]  dst_in,
    input  logic        we_in,
    input  logic [2:0]  cond,
    output logic        out_valid,
    output logic [15:0] result_q,
    output logic [3:0]  dst_q,
    output logic        we_q,
    output logic        flag_z,
    output logic        flag_v,
    output logic        flag_n,
    output logic        br_taken
);
    logic        r_valid, r_we, r_z, r_v, r_n;
    logic [15:0] r_result;
    logic [3:0]  r_dst;
    logic        w_acc, w_upd_z, w_upd_vn, w_z, w_v, w_n;
    logic [7:0]  w_cond_tbl;

    assign w_acc    = in_valid & ~stall & ~flush;
    assign w_upd_vn = w_acc & (op_class == 2'b01);
    assign w_upd_z  = w_acc & (op_class[0] ^ op_class[1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_we     <= 1'b0;
            r_result <= 16'h0000;
            r_dst    <= 4'h0;
            r_z      <= 1'b0;
            r_v      <= 1'b0;
            r_n      <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
        end else if (!stall) begin
            r_valid <= in_valid;
            r_we    <= in_valid & we_in;
            if (in_valid) begin
                r_result <= result;
                r_dst    <= dst_in;
            end
            if (w_upd_z)
                r_z <= zr_in;
            if (w_upd_vn) begin
                r_v <= ov_in;
                r_n <= result[15];
            end
        end
    end

`ifdef FLAG_BYPASS_EN
    assign w_z = w_upd_z  ? zr_in      : r_z;
    assign w_v = w_upd_vn ? ov_in      : r_v;
    assign w_n = w_upd_vn ? result[15] : r_n;
`else
    assign w_z = r_z;
    assign w_v = r_v;
    assign w_n = r_n;
`endif

    // Entry k is the branch outcome for cond == k; 100 reduces to Z | !N.
    assign w_cond_tbl = {1'b1, w_v, w_n | w_z, w_z | ~w_n, w_n, ~w_z & ~w_n, w_z, ~w_z};
    assign br_taken   = w_cond_tbl[cond];

    assign out_valid = r_valid;
    assign result_q  = r_result;
    assign dst_q     = r_dst;
    assign we_q      = r_we;
    assign flag_z    = r_z;
    assign flag_v    = r_v;
    assign flag_n    = r_n;
endmodule

// File: tb/tb_exec_flag_reg.sv
// tb_exec_flag_reg: directed bench for exec_flag_reg with a spec-level model checked every cycle.
// Honours FLAG_BYPASS_EN the same way as the design.
module tb_exec_flag_reg;
    logic        clk = 1'b0, rst_n = 1'b1;
    logic        in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [1:0]  op_class = 2'b00;
    logic [15:0] result = 16'h0000;
    logic        zr_in = 1'b0, ov_in = 1'b0, we_in = 1'b0;
    logic [3:0]  dst_in = 4'h0;
    logic [2:0]  cond = 3'b000;
    logic        out_valid, we_q, flag_z, flag_v, flag_n, br_taken;
    logic [15:0] result_q;
    logic [3:0]  dst_q;
    int          checks = 0, failures = 0;

    exec_flag_reg dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .op_class(op_class), .result(result), .zr_in(zr_in), .ov_in(ov_in),
        .dst_in(dst_in), .we_in(we_in), .cond(cond), .out_valid(out_valid),
        .result_q(result_q), .dst_q(dst_q), .we_q(we_q), .flag_z(flag_z),
        .flag_v(flag_v), .flag_n(flag_n), .br_taken(br_taken)
    );

    always #5 clk = ~clk;

    // Model state
    bit        m_valid = 0, m_we = 0, m_z = 0, m_v = 0, m_n = 0;
    bit [15:0] m_res = 0;
    bit [3:0]  m_dst = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0; m_we = 0; m_res = 0; m_dst = 0; m_z = 0; m_v = 0; m_n = 0;
        end else if (flush) begin
            m_valid = 0; m_we = 0;
        end else if (!stall) begin
            m_valid = in_valid;
            m_we    = in_valid && we_in;
            if (in_valid) begin
                m_res = result;
                m_dst = dst_in;
                if (op_class == 2'd1) begin
                    m_z = zr_in; m_v = ov_in; m_n = result[15];
                end else if (op_class == 2'd2) begin
                    m_z = zr_in;
                end
            end
        end
    end

    function automatic bit br_of(input bit [2:0] c, input bit z, input bit v, input bit n);
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit m_br();
        bit z, v, n;
        z = m_z; v = m_v; n = m_n;
`ifdef FLAG_BYPASS_EN
        if (in_valid && !stall && !flush && op_class == 2'd1) begin
            z = zr_in; v = ov_in; n = result[15];
        end else if (in_valid && !stall && !flush && op_class == 2'd2) begin
            z = zr_in;
        end
`endif
        return br_of(cond, z, v, n);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        chk("m_out_valid", 16'(out_valid), 16'(m_valid));
        chk("m_result_q", result_q, m_res);
        chk("m_dst_q", 16'(dst_q), 16'(m_dst));
        chk("m_we_q", 16'(we_q), 16'(m_we));
        chk("m_flag_z", 16'(flag_z), 16'(m_z));
        chk("m_flag_v", 16'(flag_v), 16'(m_v));
        chk("m_flag_n", 16'(flag_n), 16'(m_n));
        chk("m_br_taken", 16'(br_taken), 16'(m_br()));
    end

    initial begin
        bit [7:0] sweep_exp;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 16'(out_valid), 16'h0);
        chk("rst_result", result_q, 16'h0000);
        chk("rst_flag_z", 16'(flag_z), 16'h0);
        rst_n = 1'b1;
        // Arithmetic accept
        in_valid = 1; op_class = 2'd1; result = 16'h8000; zr_in = 0; ov_in = 1; dst_in = 4'h3; we_in = 1;
        tick();
        in_valid = 0; cond = 3'b011;
        #1;
        chk("arith_valid", 16'(out_valid), 16'h1);
        chk("arith_result", result_q, 16'h8000);
        chk("arith_dst", 16'(dst_q), 16'h3);
        chk("arith_we", 16'(we_q), 16'h1);
        chk("arith_zvn", {13'h0, flag_z, flag_v, flag_n}, 16'h3);
        chk("arith_br011", 16'(br_taken), 16'h1);
        // Shift accept holds V and N
        in_valid = 1; op_class = 2'd2; result = 16'h0000; zr_in = 1; ov_in = 0;
        tick();
        in_valid = 0; cond = 3'b001;
        #1;
        chk("shift_zvn", {13'h0, flag_z, flag_v, flag_n}, 16'h7);
        chk("shift_br001", 16'(br_taken), 16'h1);
        cond = 3'b110;
        #1;
        chk("shift_br110", 16'(br_taken), 16'h1);
        // Bubble
        tick();
        chk("bubble_valid", 16'(out_valid), 16'h0);
        chk("bubble_we", 16'(we_q), 16'h0);
        chk("bubble_result", result_q, 16'h0000);
        chk("bubble_dst", 16'(dst_q), 16'h3);
        // Stall then flush
        in_valid = 1; op_class = 2'd0; result = 16'h1234; dst_in = 4'h5; we_in = 1;
        tick();
        stall = 1; op_class = 2'd1; result = 16'hffff; dst_in = 4'ha; we_in = 0; zr_in = 0; ov_in = 0;
        repeat (3) tick();
        chk("stall_valid", 16'(out_valid), 16'h1);
        chk("stall_result", result_q, 16'h1234);
        chk("stall_dst", 16'(dst_q), 16'h5);
        chk("stall_we", 16'(we_q), 16'h1);
        chk("stall_zvn", {13'h0, flag_z, flag_v, flag_n}, 16'h7);
        flush = 1;
        tick();
        chk("flush_valid", 16'(out_valid), 16'h0);
        chk("flush_we", 16'(we_q), 16'h0);
        chk("flush_result", result_q, 16'h1234);
        chk("flush_zvn", {13'h0, flag_z, flag_v, flag_n}, 16'h7);
        flush = 0; stall = 0;
        // Condition sweep with all flags clear
        in_valid = 1; op_class = 2'd1; result = 16'h0001; zr_in = 0; ov_in = 0; dst_in = 4'h7; we_in = 1;
        tick();
        in_valid = 0;
        sweep_exp = 8'b1001_0101;
        for (int c = 0; c < 8; c++) begin
            cond = 3'(c);
            #1;
            chk($sformatf("sweep_cond%0d", c), 16'(br_taken), 16'(sweep_exp[c]));
        end
        tick();
        // Same-cycle flag source
        cond = 3'b001; in_valid = 1; op_class = 2'd1; zr_in = 1; ov_in = 0; result = 16'h0000;
        #1;
`ifdef FLAG_BYPASS_EN
        chk("bypass_br", 16'(br_taken), 16'h1);
`else
        chk("bypass_br", 16'(br_taken), 16'h0);
`endif
        tick();
        in_valid = 0;
        chk("bypass_z_after", 16'(flag_z), 16'h1);
        // Reset during stall
        stall = 1; in_valid = 1; result = 16'hbeef;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 16'(out_valid), 16'h0);
        chk("rst_mid_we", 16'(we_q), 16'h0);
        chk("rst_mid_result", result_q, 16'h0000);
        chk("rst_mid_dst", 16'(dst_q), 16'h0);
        chk("rst_mid_zvn", {13'h0, flag_z, flag_v, flag_n}, 16'h0);
        rst_n = 1'b1;
        stall = 0; in_valid = 1; op_class = 2'd1; result = 16'habcd; zr_in = 0; ov_in = 1; dst_in = 4'h2; we_in = 0;
        tick();
        in_valid = 0;
        chk("post_rst_valid", 16'(out_valid), 16'h1);
        chk("post_rst_result", result_q, 16'habcd);
        chk("post_rst_we", 16'(we_q), 16'h0);
        chk("post_rst_zvn", {13'h0, flag_z, flag_v, flag_n}, 16'h3);
        // Mixed traffic checked by the model
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            stall    = 1'($urandom_range(0, 4) == 0);
            flush    = 1'($urandom_range(0, 6) == 0);
            op_class = 2'($urandom_range(0, 3));
            result   = 16'($urandom);
            zr_in    = 1'($urandom);
            ov_in    = 1'($urandom);
            dst_in   = 4'($urandom);
            we_in    = 1'($urandom);
            cond     = 3'($urandom);
            tick();
        end
        in_valid = 0; stall = 0; flush = 0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/exec_flag_reg.md
EXEC_FLAG_REG -- requirements
Module: exec_flag_reg

Interface
REQ-001 SHALL have clock clk, input, 1 bit; all state changes on its rising edge.
REQ-002 SHALL have reset rst_n, input, 1 bit; asynchronous, active-low.
REQ-003 SHALL have in_valid, input, 1: execute-stage result present this cycle.
REQ-004 SHALL have stall, input, 1: downstream cannot accept; hold all state.
REQ-005 SHALL have flush, input, 1: discard in-flight and incoming instruction.
REQ-006 SHALL have op_class, input, 2: 00 no flag update, 01 arith (Z,V,N), 10 shift/logic (Z only), 11 no flag update.
REQ-007 SHALL have result, input, 16: ALU/shifter output.
REQ-008 SHALL have zr_in, ov_in, input, 1 each: zero and overflow from ALU/shifter.
REQ-009 SHALL have dst_in, input, 4, and we_in, input, 1: destination register and write enable.
REQ-010 SHALL have cond, input, 3: branch condition code.
REQ-011 SHALL have out_valid, output, 1; result_q, output, 16; dst_q, output, 4; we_q, output, 1: registered stage outputs.
REQ-012 SHALL have flag_z, flag_v, flag_n, output, 1 each: architectural condition flags.
REQ-013 SHALL have br_taken, output, 1: combinational evaluation of cond.

Function
REQ-014 Accept: in_valid=1, stall=0, flush=0 at a rising edge -> result_q, dst_q, we_q captured, out_valid=1 next cycle; latency exactly 1 cycle.
REQ-015 Bubble: in_valid=0, stall=0, flush=0 -> out_valid=0, we_q=0; result_q, dst_q unchanged.
REQ-016 Stall: stall=1, flush=0 -> every register, including flags, holds its value.
REQ-017 Flush: flush=1 -> out_valid=0, we_q=0, flags unchanged; flush overrides stall and in_valid.
REQ-018 Flags update only on an accepting edge (REQ-014); op_class 01: Z<=zr_in, V<=ov_in, N<=result[15]; op_class 10: Z<=zr_in, V and N hold; op_class 00/11: all hold.
REQ-019 Flags persist across bubbles, stalls and flushes until the next qualifying accept.
REQ-020 br_taken per cond, from registered flags: 000 !Z; 001 Z; 010 !Z&!N; 011 N; 100 Z|(!Z&!N); 101 N|Z; 110 V; 111 1.
REQ-021 we_q SHALL equal we_in captured on accept, forced 0 whenever out_valid=0.
REQ-022 No internal arithmetic on result; data passes unmodified, all 16 bits.

Reset
REQ-023 rst_n=0 asynchronously forces out_valid=0, we_q=0, result_q=16'h0000, dst_q=4'h0, flag_z=0, flag_v=0, flag_n=0, independent of clk.
REQ-024 Reset asserted mid-stall or mid-flush SHALL take priority; first accept after deassertion behaves per REQ-014.

Configuration
REQ-025 Macro FLAG_BYPASS_EN SHALL select br_taken flag source.
REQ-026 Defined: when an accept with qualifying op_class occurs this cycle, br_taken uses the incoming flag values (zr_in, ov_in, result[15] per REQ-018 masking) instead of registered flags; otherwise registered flags.
REQ-027 Undefined: br_taken uses registered flags only; no combinational path from zr_in/ov_in/result to br_taken.

Verification
REQ-028 Reset: rst_n=0 between edges with stage loaded -> all outputs 0 immediately, before next clk edge.
REQ-029 Arith accept: op_class=01, result=16'h8000, zr_in=0, ov_in=1 -> next cycle out_valid=1, result_q=16'h8000, Z=0, V=1, N=1; cond=011 -> br_taken=1.
REQ-030 Shift accept after REQ-029: op_class=10, result=16'h0000, zr_in=1, ov_in=0 -> Z=1, V=1, N=1 (held); cond=001 -> br_taken=1, cond=110 -> 1.
REQ-031 Stall then flush: load result=16'h1234, dst=4'h5, we=1; stall=1 for 3 cycles with new inputs -> outputs hold 16'h1234/5/1; then stall=1, flush=1 -> out_valid=0, we_q=0, flags unchanged.
REQ-032 Bypass: registered Z=0, accept op_class=01 with zr_in=1, cond=001 same cycle -> br_taken=1 with FLAG_BYPASS_EN, 0 without.
REQ-033 Condition sweep: flags Z=0,N=0,V=0 -> cond 000..111 give 1,0,1,0,1,0,0,1.
